// File: rtl/com_write_if.sv
// Controller/TX-RAM bundle for the reply-packet writer.
// master drives the controller and TX-engine inputs, slave is the writer.
interface com_write_if;
    logic        fs;
    logic        fd;
    logic        fs_eth;
    logic        fd_eth;
    logic [7:0]  txa;
    logic [7:0]  txd;
    logic        txen;
    logic [15:0] password;
    logic [3:0]  btype;
    logic [11:0] com_cmd;
    logic [39:0] trgg_cmd;

    modport master (
        output fs, fd_eth, password, btype, com_cmd, trgg_cmd,
        input  fd, fs_eth, txa, txd, txen
    );

    modport slave (
        input  fs, fd_eth, password, btype, com_cmd, trgg_cmd,
        output fd, fs_eth, txa, txd, txen
    );
endinterface

// File: rtl/com_write.sv
// Reply-packet writer: latches command fields, streams an 18-byte
// packet into the Ethernet TX RAM, then hands off to the TX engine.
module com_write #(
    parameter logic [7:0]  RAM_ADDR_INIT = 8'h0A,
    parameter logic [15:0] STD_HEAD      = 16'h55AA,
    parameter logic [7:0]  NUM           = 8'h12
) (
    input  logic       clk,
    input  logic       rst,
    com_write_if.slave bus
);

    localparam logic [6:0] S_IDLE = 7'b0000001;
    localparam logic [6:0] S_WAIT = 7'b0000010;
    localparam logic [6:0] S_LOAD = 7'b0000100;
    localparam logic [6:0] S_CALC = 7'b0001000;
    localparam logic [6:0] S_WORK = 7'b0010000;
    localparam logic [6:0] S_SEND = 7'b0100000;
    localparam logic [6:0] S_DONE = 7'b1000000;

    logic [6:0]  r_state;
    logic [7:0]  r_num;
    logic [15:0] r_didx;
    logic [15:0] r_func;
    logic [3:0]  r_rate;
    logic [3:0]  r_lfilt;
    logic [3:0]  r_hfilt;
    logic [3:0]  r_trgg0;
    logic [3:0]  r_trgg1;
    logic [15:0] r_dly0;
    logic [15:0] r_dly1;
    logic [15:0] r_part;
    logic [7:0]  r_txa;
    logic [7:0]  r_txd;
    logic        r_txen;

    logic [15:0] w_func;
    logic [15:0] w_rate;
    logic [15:0] w_filt;
    logic [15:0] w_trgg;
    logic [15:0] w_part;
    logic [15:0] w_word;
    logic [7:0]  w_byte;
    logic        w_wr;

    always_comb begin
        w_func = 16'h0000;
        case (bus.btype)
            4'd1:    w_func = 16'h001E;
            4'd2:    w_func = 16'h004C;
            4'd3:    w_func = 16'h0097;
            4'd4:    w_func = 16'h002D;
            4'd5:    w_func = 16'h00D2;
            default: w_func = 16'h0000;
        endcase
    end

    assign w_rate = {12'h000, r_rate};
    assign w_filt = {4'h0, r_lfilt, 4'h0, r_hfilt};
    assign w_trgg = {4'h0, r_trgg0, 4'h0, r_trgg1};
    // 16-bit sum, carries out of bit 15 dropped
    assign w_part = r_didx + r_func + w_rate + w_filt
                  + w_trgg + r_dly0 + r_dly1;

    always_comb begin
        w_word = 16'h0000;
        case (r_num[4:1])
            4'd0:    w_word = STD_HEAD;
            4'd1:    w_word = r_didx;
            4'd2:    w_word = r_func;
            4'd3:    w_word = w_rate;
            4'd4:    w_word = w_filt;
            4'd5:    w_word = w_trgg;
            4'd6:    w_word = r_dly0;
            4'd7:    w_word = r_dly1;
            4'd8:    w_word = r_part;
            default: w_word = 16'h0000;
        endcase
    end

    assign w_byte = r_num[0] ? w_word[7:0] : w_word[15:8];
    assign w_wr   = (r_state == S_WORK) && (r_num < NUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= 8'h00;
        end else begin
            unique case (1'b1)
                r_state[0]: r_state <= S_WAIT;
                r_state[1]: if (bus.fs) r_state <= S_LOAD;
                r_state[2]: r_state <= S_CALC;
                r_state[3]: r_state <= S_WORK;
                r_state[4]: begin
                    if (r_num == NUM) begin
                        r_state <= S_SEND;
                        r_num   <= 8'h00;
                    end else begin
                        r_num <= r_num + 8'h01;
                    end
                end
                r_state[5]: if (bus.fd_eth) r_state <= S_DONE;
                r_state[6]: if (!bus.fs) r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_didx  <= 16'h0000;
            r_func  <= 16'h0000;
            r_rate  <= 4'h0;
            r_lfilt <= 4'h0;
            r_hfilt <= 4'h0;
            r_trgg0 <= 4'h0;
            r_trgg1 <= 4'h0;
            r_dly0  <= 16'h0000;
            r_dly1  <= 16'h0000;
            r_part  <= 16'h0000;
        end else begin
            if (r_state == S_LOAD) begin
                r_didx  <= bus.password;
                r_func  <= w_func;
                r_rate  <= bus.com_cmd[11:8];
                r_lfilt <= bus.com_cmd[7:4];
                r_hfilt <= bus.com_cmd[3:0];
                r_trgg0 <= bus.trgg_cmd[39:36];
                r_trgg1 <= bus.trgg_cmd[35:32];
                r_dly0  <= bus.trgg_cmd[31:16];
                r_dly1  <= bus.trgg_cmd[15:0];
            end
            if (r_state == S_CALC) begin
                r_part <= w_part;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txen <= 1'b0;
            r_txa  <= RAM_ADDR_INIT;
            r_txd  <= 8'h00;
        end else if (w_wr) begin
            r_txen <= 1'b1;
            r_txa  <= RAM_ADDR_INIT + r_num;
            r_txd  <= w_byte;
        end else begin
            r_txen <= 1'b0;
            r_txa  <= RAM_ADDR_INIT;
            r_txd  <= 8'h00;
        end
    end

    assign bus.txen   = r_txen;
    assign bus.txa    = r_txa;
    assign bus.txd    = r_txd;
    assign bus.fs_eth = (r_state == S_SEND);
    assign bus.fd     = (r_state == S_DONE);

endmodule

// File: tb/tb_com_write.sv
// Bench for com_write: vector table of reply packets, byte scoreboard
// checked on every TX RAM write, plus hold/reset/back-to-back sequences.
module tb_com_write;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    com_write_if bus ();

    com_write dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  bt;
        logic [15:0] pw;
        logic [11:0] cc;
        logic [39:0] tc;
        logic [15:0] func;
        logic [15:0] part;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    vec_t v [7];
    wr_t  q [$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(vec_t x);
        bus.btype    = x.bt;
        bus.password = x.pw;
        bus.com_cmd  = x.cc;
        bus.trgg_cmd = x.tc;
    endtask

    task automatic push_exp(vec_t x);
        logic [15:0] w [9];
        wr_t e;
        w = '{16'h55AA, x.pw, x.func,
              {12'h000, x.cc[11:8]},
              {4'h0, x.cc[7:4], 4'h0, x.cc[3:0]},
              {4'h0, x.tc[39:36], 4'h0, x.tc[35:32]},
              x.tc[31:16], x.tc[15:0], x.part};
        for (int k = 0; k < 18; k++) begin
            e.a = 8'h0A + 8'(k);
            e.d = k[0] ? w[k >> 1][7:0] : w[k >> 1][15:8];
            q.push_back(e);
        end
    endtask

    // Every TX RAM write must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.txen) begin
            if (q.size() == 0) begin
                chk("extra_write", {bus.txa, bus.txd}, 16'hxxxx);
            end else begin
                e = q.pop_front();
                chk("tx_byte", {bus.txa, bus.txd}, {e.a, e.d});
            end
        end
    end

    task automatic wait_send(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.fs_eth) break;
        end
    endtask

    task automatic finish_pkt(int hold);
        logic bad;
        bad = 1'b0;
        chk("sb_drain", q.size(), 0);
        repeat (hold) begin
            @(negedge clk);
            if (!bus.fs_eth || bus.txen || bus.fd) bad = 1'b1;
        end
        chk("send_hold", bad, 1'b0);
        bus.fd_eth = 1'b1;
        @(negedge clk);
        chk("fd_set", {bus.fd, bus.fs_eth}, 2'b10);
        bus.fd_eth = 1'b0;
        repeat (3) @(negedge clk);
        chk("fd_hold", bus.fd, 1'b1);
        bus.fs = 1'b0;
        @(negedge clk);
        chk("fd_clear", {bus.fd, bus.fs_eth, bus.txen}, 3'b000);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        v[0] = '{4'h1, 16'h1234, 12'hABC, 40'h123456789A, 16'h001E, 16'hCB5A};
        v[1] = '{4'h3, 16'hFFFF, 12'h000, 40'h00FFFF0000, 16'h0097, 16'h0095};
        v[2] = '{4'h0, 16'h0100, 12'h123, 40'h4500010002, 16'h0000, 16'h070C};
        v[3] = '{4'h9, 16'hABCD, 12'h000, 40'h0000000000, 16'h0000, 16'hABCD};
        v[4] = '{4'h2, 16'h0000, 12'hFFF, 40'hFFFFFFFFFF, 16'h004C, 16'h1E77};
        v[5] = '{4'h4, 16'h0002, 12'h000, 40'h0000000000, 16'h002D, 16'h002F};
        v[6] = '{4'h5, 16'h0003, 12'h000, 40'h0000000000, 16'h00D2, 16'h00D5};

        bus.fs     = 1'b0;
        bus.fd_eth = 1'b0;
        drive(v[3]);
        repeat (3) @(negedge clk);
        chk("reset_out",
            {bus.txa, bus.txd, bus.txen, bus.fs_eth, bus.fd},
            {8'h0A, 8'h00, 3'b000});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            drive(v[i]);
            push_exp(v[i]);
            bus.fs = 1'b1;
            wait_send(lat);
            chk("fs_eth_lat", lat, 22);
            finish_pkt((i == 0) ? 50 : 2);
        end

        // reset while byte 8 is being written, fs kept high
        drive(v[1]);
        push_exp(v[1]);
        bus.fs = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (q.size() > 10 && n < 100);
        chk("reach_num8", q.size(), 10);
        rst = 1'b1;
        #1;
        chk("rst_mid",
            {bus.txa, bus.txd, bus.txen, bus.fs_eth, bus.fd},
            {8'h0A, 8'h00, 3'b000});
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_exp(v[1]);
        wait_send(lat);
        chk("rst_restart_lat", lat, 23);
        finish_pkt(2);

        // inputs change mid-packet, stray fd_eth, then back-to-back
        drive(v[2]);
        push_exp(v[2]);
        bus.fs = 1'b1;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        drive(v[5]);
        bus.fd_eth = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.fd_eth = 1'b0;
        wait_send(lat);
        chk("b2b_first_lat", lat, 13);
        chk("sb_drain_b2b", q.size(), 0);
        bus.fd_eth = 1'b1;
        @(negedge clk);
        chk("b2b_fd", bus.fd, 1'b1);
        bus.fd_eth = 1'b0;
        bus.fs     = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {bus.fd, bus.fs_eth}, 2'b00);
        drive(v[4]);
        push_exp(v[4]);
        bus.fs = 1'b1;
        wait_send(lat);
        chk("b2b_second_lat", lat, 23);
        finish_pkt(2);

        repeat (3) @(negedge clk);
        chk("sb_final", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
